// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and constants for the branch update sequencer
package bpu_pkg;

    // Reorder depth mirrors the predictor FIFO so a tag is directly a slot index.
    localparam int TAG_DEPTH = 8;
    localparam int TAG_W     = $clog2(TAG_DEPTH);

    // Value the predictor table is swept to during initialisation (weakly not-taken).
    localparam logic [1:0] BPU_INIT_STATUS = 2'b01;

    typedef struct packed {
        logic        taken;
        logic        jump;
        logic [31:0] address;
    } branch_report_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpu_seq_state_t;

endpackage

// File: rtl/branch_report_buffer.sv
// rtl/branch_report_buffer.sv - tag-indexed reorder slots with in-order head pointer
module branch_report_buffer
    import bpu_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clear_i,
    input  logic                 wr_a_i,
    input  logic [TAG_W-1:0]     wr_a_tag_i,
    input  branch_report_t       wr_a_data_i,
    input  logic                 wr_b_i,
    input  logic [TAG_W-1:0]     wr_b_tag_i,
    input  branch_report_t       wr_b_data_i,
    input  logic                 issue_i,
    output logic [TAG_DEPTH-1:0] valid_o,
    output logic [TAG_W-1:0]     head_o,
    output branch_report_t       head_data_o
);

    branch_report_t       slots_q [TAG_DEPTH];
    logic [TAG_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     head_q;

    // Slot occupancy and head pointer; clear drops everything, including same-cycle writes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            head_q  <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
            head_q  <= '0;
        end else begin
            if (issue_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (wr_a_i) begin
                valid_q[wr_a_tag_i] <= 1'b1;
            end
            if (wr_b_i) begin
                valid_q[wr_b_tag_i] <= 1'b1;
            end
        end
    end

    // Payload storage; contents only matter while the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (wr_a_i && !clear_i) begin
            slots_q[wr_a_tag_i] <= wr_a_data_i;
        end
        if (wr_b_i && !clear_i) begin
            slots_q[wr_b_tag_i] <= wr_b_data_i;
        end
    end

    assign valid_o     = valid_q;
    assign head_o      = head_q;
    assign head_data_o = slots_q[head_q];

endmodule

// File: rtl/branch_update_sequencer.sv
// rtl/branch_update_sequencer.sv - in-order predictor update sequencer with init sweep (BPU_INIT_SWEEP_EN)
module branch_update_sequencer
    import bpu_pkg::*;
#(
    parameter  int TABLE_SIZE = 1024,
    localparam int IDX_W      = $clog2(TABLE_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             mispredicted_i,
    input  logic             clear_i,
    input  logic             a_valid_i,
    input  logic [TAG_W-1:0] a_tag_i,
    input  logic             a_taken_i,
    input  logic             a_jump_i,
    input  logic [31:0]      a_address_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [TAG_W-1:0] b_tag_i,
    input  logic             b_taken_i,
    input  logic             b_jump_i,
    input  logic [31:0]      b_address_i,
    output logic             b_ready_o,
    output logic             executed_o,
    output logic             taken_o,
    output logic             jump_o,
    output logic [31:0]      exu_address_o,
    output logic             init_write_o,
    output logic [IDX_W-1:0] init_index_o,
    output logic             busy_o
);

    logic                 run;
    logic                 buf_clear;
    logic                 wr_a;
    logic                 wr_b;
    logic                 issue;
    logic [TAG_DEPTH-1:0] valid;
    logic [TAG_W-1:0]     head;
    branch_report_t       head_data;

`ifdef BPU_INIT_SWEEP_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_SIZE - 1);

    bpu_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;

    // State and sweep counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= INIT;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    // Sweep one table entry per cycle, then run until a clear request restarts the sweep.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            INIT: begin
                if (sweep_cnt_q == LAST_IDX) begin
                    state_d     = RUN;
                    sweep_cnt_d = '0;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (clear_i) begin
                    state_d     = INIT;
                    sweep_cnt_d = '0;
                end
            end
            default: begin
                state_d     = INIT;
                sweep_cnt_d = '0;
            end
        endcase
    end

    assign run          = (state_q == RUN);
    assign init_write_o = (state_q == INIT);
    assign init_index_o = sweep_cnt_q;
    assign busy_o       = (state_q == INIT);
`else
    // Tables come up from their initial contents, so the sequencer is always running.
    assign run          = 1'b1;
    assign init_write_o = 1'b0;
    assign init_index_o = '0;
    assign busy_o       = 1'b0;
`endif

    // clear outranks flush/mispredict, but both empty the buffer and rewind head.
    assign buf_clear = run & (clear_i | flush_i | mispredicted_i);

    // A wins a same-tag collision; an occupied slot refuses a new report.
    assign a_ready_o = run & ~valid[a_tag_i];
    assign b_ready_o = run & ~valid[b_tag_i] & ~(a_valid_i & (a_tag_i == b_tag_i));

    assign wr_a  = a_valid_i & a_ready_o;
    assign wr_b  = b_valid_i & b_ready_o;
    assign issue = run & valid[head];

    branch_report_buffer u_buffer (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (buf_clear),
        .wr_a_i      (wr_a),
        .wr_a_tag_i  (a_tag_i),
        .wr_a_data_i ('{taken: a_taken_i, jump: a_jump_i, address: a_address_i}),
        .wr_b_i      (wr_b),
        .wr_b_tag_i  (b_tag_i),
        .wr_b_data_i ('{taken: b_taken_i, jump: b_jump_i, address: b_address_i}),
        .issue_i     (issue),
        .valid_o     (valid),
        .head_o      (head),
        .head_data_o (head_data)
    );

    // Payload is gated by the strobe so the predictor sees zeros when idle.
    assign executed_o    = issue;
    assign taken_o       = issue & head_data.taken;
    assign jump_o        = issue & head_data.jump;
    assign exu_address_o = issue ? head_data.address : 32'h0;

endmodule

// File: tb/tb_branch_update_sequencer.sv
// tb/tb_branch_update_sequencer.sv - directed self-checking bench for branch_update_sequencer
module tb_branch_update_sequencer;
    import bpu_pkg::*;

    localparam int TABLE_SIZE = 1024;
    localparam int IDX_W      = 10;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             flush_i, mispredicted_i, clear_i;
    logic             a_valid_i, a_taken_i, a_jump_i, a_ready_o;
    logic [TAG_W-1:0] a_tag_i;
    logic [31:0]      a_address_i;
    logic             b_valid_i, b_taken_i, b_jump_i, b_ready_o;
    logic [TAG_W-1:0] b_tag_i;
    logic [31:0]      b_address_i;
    logic             executed_o, taken_o, jump_o;
    logic [31:0]      exu_address_o;
    logic             init_write_o, busy_o;
    logic [IDX_W-1:0] init_index_o;

    int n_tests = 0;
    int n_fail  = 0;

    branch_update_sequencer #(.TABLE_SIZE(TABLE_SIZE)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .mispredicted_i(mispredicted_i), .clear_i(clear_i),
        .a_valid_i(a_valid_i), .a_tag_i(a_tag_i), .a_taken_i(a_taken_i),
        .a_jump_i(a_jump_i), .a_address_i(a_address_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_tag_i(b_tag_i), .b_taken_i(b_taken_i),
        .b_jump_i(b_jump_i), .b_address_i(b_address_i), .b_ready_o(b_ready_o),
        .executed_o(executed_o), .taken_o(taken_o), .jump_o(jump_o),
        .exu_address_o(exu_address_o), .init_write_o(init_write_o),
        .init_index_o(init_index_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        a_valid_i = 0; a_tag_i = '0; a_taken_i = 0; a_jump_i = 0; a_address_i = '0;
        b_valid_i = 0; b_tag_i = '0; b_taken_i = 0; b_jump_i = 0; b_address_i = '0;
        flush_i = 0; mispredicted_i = 0; clear_i = 0;
    endtask

    task automatic send_a(input int tag, input bit tk, input bit jp, input logic [31:0] ad);
        a_valid_i = 1; a_tag_i = TAG_W'(tag); a_taken_i = tk; a_jump_i = jp; a_address_i = ad;
    endtask

    task automatic send_b(input int tag, input bit tk, input bit jp, input logic [31:0] ad);
        b_valid_i = 1; b_tag_i = TAG_W'(tag); b_taken_i = tk; b_jump_i = jp; b_address_i = ad;
    endtask

    task automatic expect_issue(input string t, input bit ex, input bit tk, input bit jp,
                                input logic [31:0] ad);
        chk({t, "_executed"}, 64'(executed_o), 64'(ex));
        if (ex) begin
            chk({t, "_taken"}, 64'(taken_o), 64'(tk));
            chk({t, "_jump"}, 64'(jump_o), 64'(jp));
            chk({t, "_address"}, 64'(exu_address_o), 64'(ad));
        end
    endtask

`ifdef BPU_INIT_SWEEP_EN
    // Expects a full sweep starting now at index 0, then RUN with both ports open.
    task automatic sweep(input string t);
        for (int k = 0; k < TABLE_SIZE; k++) begin
            @(negedge clk_i);
            chk({t, "_index"}, 64'(init_index_o), 64'(k));
            if (k == 0 || k == TABLE_SIZE - 1) begin
                chk({t, "_busy"}, 64'(busy_o), 64'd1);
                chk({t, "_write"}, 64'(init_write_o), 64'd1);
                chk({t, "_ready_in_init"}, 64'(a_ready_o), 64'd0);
                chk({t, "_exec_in_init"}, 64'(executed_o), 64'd0);
            end
            step();
        end
        @(negedge clk_i);
        chk({t, "_busy_done"}, 64'(busy_o), 64'd0);
        chk({t, "_write_done"}, 64'(init_write_o), 64'd0);
        chk({t, "_a_ready_run"}, 64'(a_ready_o), 64'd1);
        chk({t, "_b_ready_run"}, 64'(b_ready_o), 64'd1);
        step();
    endtask
`endif

    initial begin
        idle();
        rst_n_i = 0;
        step();
        @(negedge clk_i);
        chk("rst_executed", 64'(executed_o), 64'd0);
        chk("rst_taken", 64'(taken_o), 64'd0);
        chk("rst_jump", 64'(jump_o), 64'd0);
        chk("rst_address", 64'(exu_address_o), 64'd0);
        chk("rst_index", 64'(init_index_o), 64'd0);
`ifdef BPU_INIT_SWEEP_EN
        chk("rst_busy", 64'(busy_o), 64'd1);
        chk("rst_write", 64'(init_write_o), 64'd1);
        chk("rst_a_ready", 64'(a_ready_o), 64'd0);
        chk("rst_b_ready", 64'(b_ready_o), 64'd0);
`else
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_write", 64'(init_write_o), 64'd0);
        chk("rst_a_ready", 64'(a_ready_o), 64'd1);
        chk("rst_b_ready", 64'(b_ready_o), 64'd1);
`endif
        step();
        rst_n_i = 1;
`ifdef BPU_INIT_SWEEP_EN
        sweep("reset_sweep");
`endif

        // Reorder: tag 1 arrives before tag 0.
        send_b(1, 1, 0, 32'h100);
        @(negedge clk_i);
        chk("reorder_b_ready", 64'(b_ready_o), 64'd1);
        expect_issue("reorder_c0", 0, 0, 0, 0);
        step(); idle();
        send_a(0, 0, 0, 32'h80);
        @(negedge clk_i);
        expect_issue("reorder_c1", 0, 0, 0, 0);
        step(); idle();
        @(negedge clk_i);
        expect_issue("reorder_tag0", 1, 0, 0, 32'h80);
        step();
        @(negedge clk_i);
        expect_issue("reorder_tag1", 1, 1, 0, 32'h100);
        step();
        @(negedge clk_i);
        expect_issue("reorder_drained", 0, 0, 0, 0);
        step();
        // head should now be 2: a tag-2 report issues with minimum latency.
        send_a(2, 0, 1, 32'h200);
        step(); idle();
        @(negedge clk_i);
        expect_issue("head2_latency1", 1, 0, 1, 32'h200);
        step();

        // Collision on tag 3 (current head): A wins, B is refused.
        send_a(3, 1, 0, 32'h300);
        send_b(3, 0, 1, 32'h333);
        @(negedge clk_i);
        chk("collide_a_ready", 64'(a_ready_o), 64'd1);
        chk("collide_b_ready", 64'(b_ready_o), 64'd0);
        step(); idle();
        @(negedge clk_i);
        expect_issue("collide_payload_a", 1, 1, 0, 32'h300);
        step();
        @(negedge clk_i);
        expect_issue("collide_b_not_written", 0, 0, 0, 0);
        step();

        // Flush rewinds head to 0 before the mispredict scenario.
        flush_i = 1;
        step(); idle();
        send_a(1, 0, 0, 32'h910);
        send_b(2, 0, 0, 32'h920);
        @(negedge clk_i);
        expect_issue("flush_empty", 0, 0, 0, 0);
        chk("mp_a_ready_t1", 64'(a_ready_o), 64'd1);
        chk("mp_b_ready_t2", 64'(b_ready_o), 64'd1);
        step(); idle();
        send_a(0, 1, 1, 32'h900);
        @(negedge clk_i);
        expect_issue("mp_wait_tag0", 0, 0, 0, 0);
        step(); idle();
        send_a(3, 0, 0, 32'h930);
        mispredicted_i = 1;
        @(negedge clk_i);
        expect_issue("mp_issue_tag0", 1, 1, 1, 32'h900);
        chk("mp_a_ready_t3", 64'(a_ready_o), 64'd1);
        step(); idle();
        @(negedge clk_i);
        expect_issue("mp_after", 0, 0, 0, 0);
        for (int t = 1; t < 4; t++) begin
            a_tag_i = TAG_W'(t);
            #1;
            chk($sformatf("mp_slot%0d_cleared", t), 64'(a_ready_o), 64'd1);
        end
        step(); idle();
        send_a(0, 0, 0, 32'h940);
        step(); idle();
        @(negedge clk_i);
        expect_issue("mp_head0", 1, 0, 0, 32'h940);
        step();
        @(negedge clk_i);
        expect_issue("mp_tags_dropped", 0, 0, 0, 0);
        step();

        // Wrap: head is 1; nine reports cross the 7 -> 0 boundary.
        for (int i = 0; i < 9; i++) begin
            send_a((1 + i) % 8, i[0], i[1], 32'h1000 + 32'(i));
            @(negedge clk_i);
            chk($sformatf("wrap_ready%0d", i), 64'(a_ready_o), 64'd1);
            if (i == 0) expect_issue("wrap_first", 0, 0, 0, 0);
            else expect_issue($sformatf("wrap_issue%0d", i - 1), 1, bit'((i - 1) & 1),
                              bit'(((i - 1) >> 1) & 1), 32'h1000 + 32'(i - 1));
            step();
        end
        idle();
        @(negedge clk_i);
        expect_issue("wrap_issue8", 1, 0, 0, 32'h1008);
        step();

        // Clear with two waiting reports (head is 2, tags 3 and 4 buffered).
        send_a(3, 0, 0, 32'hA03);
        send_b(4, 0, 0, 32'hA04);
        step(); idle();
        clear_i = 1;
        @(negedge clk_i);
        expect_issue("clear_waiting", 0, 0, 0, 0);
        step(); idle();
`ifdef BPU_INIT_SWEEP_EN
        sweep("clear_sweep");
`endif
        send_a(0, 1, 0, 32'hB00);
        @(negedge clk_i);
        chk("clear_head0_ready", 64'(a_ready_o), 64'd1);
        step(); idle();
        @(negedge clk_i);
        expect_issue("clear_head0", 1, 1, 0, 32'hB00);
        a_tag_i = 3'd3;
        #1;
        chk("clear_slot3_freed", 64'(a_ready_o), 64'd1);
        step(); idle();
        @(negedge clk_i);
        expect_issue("clear_never_issue", 0, 0, 0, 0);
        step();

        // Asynchronous reset while a report is being issued (head is 1).
        send_a(1, 1, 1, 32'hC01);
        step(); idle();
        #2;
        chk("areset_pre", 64'(executed_o), 64'd1);
        rst_n_i = 0;
        #1;
        chk("areset_executed", 64'(executed_o), 64'd0);
        chk("areset_address", 64'(exu_address_o), 64'd0);
`ifdef BPU_INIT_SWEEP_EN
        chk("areset_busy", 64'(busy_o), 64'd1);
`endif
        step();
        rst_n_i = 1;
`ifdef BPU_INIT_SWEEP_EN
        sweep("areset_sweep");
`endif
        @(negedge clk_i);
        expect_issue("areset_after", 0, 0, 0, 0);
        a_tag_i = 3'd1;
        #1;
        chk("areset_slot1_freed", 64'(a_ready_o), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
